// File: rtl/graph_pxcode_gen_pkg.sv
// Shared constants for the pixel-code generator: graph geometry, channel bit
// positions and the sample-value to row mapping.
package graph_pxcode_gen_pkg;

  localparam int COLS   = 256;
  localparam int ROWS   = 128;
  localparam int ROW_W  = 7;
  localparam int NUM_CH = 5;

  localparam int CH_HUM  = 0;
  localparam int CH_TEMP = 1;
  localparam int CH_MAGX = 2;
  localparam int CH_MAGY = 3;
  localparam int CH_MAGZ = 4;

  // Full-scale 255 lands on row 0 (top), value 0 lands on the bottom row.
  function automatic logic [ROW_W-1:0] row_of(input logic [7:0] value, input int rows);
    int r;
    r = rows - 1 - int'(value >> 1);
    return r[ROW_W-1:0];
  endfunction

endpackage

// File: rtl/graph_pxcode_gen_if.sv
// Sample-in and pixel-query bus of the pixel-code generator.
// Samples: a set transfers on a cycle where smp_valid and smp_ready are both high;
// queries: px_req has no back-pressure and px_valid/px_code follow exactly two cycles later.
interface graph_pxcode_gen_if;
  import graph_pxcode_gen_pkg::*;

  logic              clr;
  logic              freeze;
  logic              smp_valid;
  logic              smp_ready;
  logic [7:0]        smp_hum;
  logic [7:0]        smp_temp;
  logic [7:0]        smp_magx;
  logic [7:0]        smp_magy;
  logic [7:0]        smp_magz;
  logic              px_req;
  logic [7:0]        px_x;
  logic [ROW_W-1:0]  px_y;
  logic              px_valid;
  logic [NUM_CH-1:0] px_code;

  modport master (
    output clr, freeze, smp_valid, smp_hum, smp_temp, smp_magx, smp_magy, smp_magz,
    output px_req, px_x, px_y,
    input  smp_ready, px_valid, px_code
  );

  modport slave (
    input  clr, freeze, smp_valid, smp_hum, smp_temp, smp_magx, smp_magy, smp_magz,
    input  px_req, px_x, px_y,
    output smp_ready, px_valid, px_code
  );

endinterface

// File: rtl/graph_pxcode_gen_trace_hit.sv
// Per-channel trace hit test: exact row match, or the vertical segment joining
// the previous column's row to this column's row when the previous column exists.
module graph_trace_hit
  import graph_pxcode_gen_pkg::*;
#(
  parameter int RW = ROW_W
) (
  input  logic [RW-1:0] row_cur,
  input  logic [RW-1:0] row_prev,
  input  logic          prev_ok,
  input  logic [RW-1:0] px_y,
  output logic          hit
);

  logic [RW-1:0] w_lo;
  logic [RW-1:0] w_hi;

  assign w_lo = (row_cur < row_prev) ? row_cur : row_prev;
  assign w_hi = (row_cur < row_prev) ? row_prev : row_cur;

  assign hit = (px_y == row_cur) | (prev_ok & (px_y >= w_lo) & (px_y <= w_hi));

endmodule

// File: rtl/graph_pxcode_gen.sv
// Scrolling five-trace graph: keeps the last COLS sample sets as row numbers and
// answers per-pixel queries with a trace-hit mask through a two-stage pipeline.
module graph_pxcode_gen #(
  parameter int COLS = graph_pxcode_gen_pkg::COLS,
  parameter int ROWS = graph_pxcode_gen_pkg::ROWS
) (
  input logic               clk,
  input logic               reset,
  graph_pxcode_gen_if.slave bus
);
  import graph_pxcode_gen_pkg::*;

  // px_x is 8 bits wide, so COLS is limited to 256.
  localparam int              AW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int              FW     = $clog2(COLS + 1);
  localparam logic [AW:0]     COLS_A = (AW + 1)'(COLS);
  localparam logic [AW-1:0]   LAST_A = AW'(COLS - 1);
  localparam logic [FW-1:0]   COLS_F = FW'(COLS);

  logic [AW-1:0]     r_wr_ptr;
  logic [FW-1:0]     r_fill;
  logic              w_accept;
  logic [7:0]        w_val [NUM_CH];

  logic [AW:0]       w_sum;
  logic [AW-1:0]     w_addr_cur;
  logic [AW-1:0]     w_addr_prev;

  logic              r_s1_v;
  logic [7:0]        r_s1_x;
  logic [ROW_W-1:0]  r_s1_y;
  logic [FW-1:0]     r_s1_fill;

  logic [15:0]       w_x_ext;
  logic [15:0]       w_thresh;
  logic              w_pop;
  logic              w_prev_ok;
  logic [NUM_CH-1:0] w_hit;

  logic              r_px_valid;
  logic [NUM_CH-1:0] r_px_code;

  assign bus.smp_ready = ~(bus.freeze | bus.clr | reset);
  assign w_accept      = bus.smp_valid & bus.smp_ready;

  assign w_val[CH_HUM]  = bus.smp_hum;
  assign w_val[CH_TEMP] = bus.smp_temp;
  assign w_val[CH_MAGX] = bus.smp_magx;
  assign w_val[CH_MAGY] = bus.smp_magy;
  assign w_val[CH_MAGZ] = bus.smp_magz;

  // wr_ptr points one past the newest entry, so column x maps to (wr_ptr + x) mod COLS.
  assign w_sum       = {1'b0, r_wr_ptr} + {1'b0, bus.px_x[AW-1:0]};
  assign w_addr_cur  = (w_sum >= COLS_A) ? AW'(w_sum - COLS_A) : w_sum[AW-1:0];
  assign w_addr_prev = (w_addr_cur == '0) ? LAST_A : w_addr_cur - 1'b1;

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= (r_wr_ptr == LAST_A) ? '0 : r_wr_ptr + 1'b1;
      if (r_fill != COLS_F) r_fill <= r_fill + 1'b1;
    end
  end

  // Stage 1: RAM reads and the operands the hit test needs, all pre-write.
  always_ff @(posedge clk) begin
    if (reset) r_s1_v <= 1'b0;
    else       r_s1_v <= bus.px_req;
  end

  always_ff @(posedge clk) begin
    r_s1_x    <= bus.px_x;
    r_s1_y    <= bus.px_y;
    r_s1_fill <= r_fill;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ROW_W-1:0] r_mem [COLS];
    logic [ROW_W-1:0] r_cur;
    logic [ROW_W-1:0] r_prev;

    always_ff @(posedge clk) begin
      if (w_accept) r_mem[r_wr_ptr] <= row_of(w_val[c], ROWS);
      r_cur  <= r_mem[w_addr_cur];
      r_prev <= r_mem[w_addr_prev];
    end

    graph_trace_hit #(.RW(ROW_W)) u_hit (
      .row_cur  (r_cur),
      .row_prev (r_prev),
      .prev_ok  (w_prev_ok),
      .px_y     (r_s1_y),
      .hit      (w_hit[c])
    );
  end

  // Column x is populated when x >= COLS - fill; its left neighbour must be too.
  assign w_x_ext   = 16'(r_s1_x);
  assign w_thresh  = 16'(COLS) - 16'(r_s1_fill);
  assign w_pop     = (w_x_ext >= w_thresh);
  assign w_prev_ok = (w_x_ext != 16'd0) && ((w_x_ext - 16'd1) >= w_thresh);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_px_valid <= 1'b0;
      r_px_code  <= '0;
    end else begin
      r_px_valid <= r_s1_v;
      r_px_code  <= (r_s1_v && w_pop) ? w_hit : '0;
    end
  end

  assign bus.px_valid = r_px_valid;
  assign bus.px_code  = r_px_code;

endmodule

// File: tb/tb_graph_pxcode_gen.sv
// Directed bench for graph_pxcode_gen with a reference history model for the
// back-to-back query run.
module tb_graph_pxcode_gen;

  localparam int COLS = 256;
  localparam int ROWS = 128;

  logic clk;
  logic reset;
  logic [39:0] smp_vec;

  graph_pxcode_gen_if bus ();

  graph_pxcode_gen #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.smp_hum  = smp_vec[7:0];
  assign bus.smp_temp = smp_vec[15:8];
  assign bus.smp_magx = smp_vec[23:16];
  assign bus.smp_magy = smp_vec[31:24];
  assign bus.smp_magz = smp_vec[39:32];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  logic [4:0]  exp_q[$];
  int          due_q[$];
  string       tag_q[$];
  logic [39:0] hist_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] q_exp;
  string      q_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check({tag_q[0], ".valid"}, 32'(bus.px_valid), 32'd1);
      check({tag_q[0], ".code"}, 32'(bus.px_code), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
      void'(tag_q.pop_front());
    end else begin
      check("px_valid_idle", 32'(bus.px_valid), 32'd0);
    end
  end

  function automatic logic [4:0] model_code(input int x, input int y);
    int fill, thr, rc, rp, lo, hi;
    logic prev_ok;
    logic [39:0] cur, prv;
    logic [4:0] code;
    fill = hist_q.size();
    thr  = COLS - fill;
    code = '0;
    if (x < thr) return code;
    cur = hist_q[x - thr];
    prev_ok = (x > 0) && (x - 1 >= thr);
    prv = prev_ok ? hist_q[x - 1 - thr] : cur;
    for (int ch = 0; ch < 5; ch++) begin
      rc = ROWS - 1 - int'(cur[8*ch +: 8] >> 1);
      rp = ROWS - 1 - int'(prv[8*ch +: 8] >> 1);
      lo = (rc < rp) ? rc : rp;
      hi = (rc < rp) ? rp : rc;
      code[ch] = (y == rc) || (prev_ok && y >= lo && y <= hi);
    end
    return code;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic rdy_exp, acc;
    logic [39:0] cap;
    rdy_exp = !bus.freeze && !bus.clr && !reset;
    acc     = bus.smp_valid && rdy_exp;
    cap     = smp_vec;
    if (bus.px_req && !reset) begin
      exp_q.push_back(q_exp);
      due_q.push_back(cyc + 2);
      tag_q.push_back(q_tag);
    end
    #1;
    check("smp_ready", 32'(bus.smp_ready), 32'(rdy_exp));
    @(posedge clk);
    if (reset) begin
      exp_q.delete(); due_q.delete(); tag_q.delete(); hist_q.delete();
    end else if (bus.clr) begin
      hist_q.delete();
    end else if (acc) begin
      hist_q.push_back(cap);
      if (hist_q.size() > COLS) void'(hist_q.pop_front());
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic put(input logic [39:0] v);
    smp_vec = v;
    bus.smp_valid = 1'b1;
    tick();
    bus.smp_valid = 1'b0;
  endtask

  task automatic query(input int x, input int y, input logic [4:0] e, input string t);
    bus.px_req = 1'b1;
    bus.px_x = 8'(x);
    bus.px_y = 7'(y);
    q_exp = e;
    q_tag = t;
    tick();
    bus.px_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int x, y, ch;
    logic [7:0] v8;
    reset = 1'b1;
    smp_vec = '0;
    bus.clr = 1'b0; bus.freeze = 1'b0; bus.smp_valid = 1'b0;
    bus.px_req = 1'b0; bus.px_x = '0; bus.px_y = '0;
    q_exp = '0; q_tag = "";
    idle(3);
    check("rst_px_valid", 32'(bus.px_valid), 32'd0);
    check("rst_px_code", 32'(bus.px_code), 32'd0);
    check("rst_smp_ready", 32'(bus.smp_ready), 32'd0);
    reset = 1'b0;

    // single sample, hum full scale
    put(40'h00_00_00_00_FF);
    query(255, 0, 5'b00001, "one_y0");
    query(255, 127, 5'b11110, "one_y127");
    query(254, 127, 5'b00000, "one_unpop");
    idle(3);

    // reset squashes an in-flight query
    query(255, 0, 5'b00001, "squashed");
    do_reset();
    idle(3);

    // vertical fill between hum=0 and hum=254
    put(40'h00_00_00_00_00);
    put(40'h00_00_00_00_FE);
    query(255, 64, 5'b00001, "vfill_255");
    query(254, 64, 5'b00000, "vfill_254");
    put(40'h00_00_00_00_64);
    query(252, 127, 5'b00000, "fill3_252");
    query(253, 127, 5'b11111, "fill3_253");
    query(254, 64, 5'b00001, "fill3_254");
    query(255, 77, 5'b00001, "fill3_255");
    idle(3);

    // 300 samples: wrap and saturate
    do_reset();
    for (int k = 0; k < 300; k++) begin
      v8 = 8'(k);
      put({5{v8}});
    end
    query(255, 106, 5'b11111, "wrap_new_hit");
    query(255, 105, 5'b00000, "wrap_new_miss");
    query(0, 105, 5'b11111, "wrap_old_hit");
    query(0, 106, 5'b00000, "wrap_old_miss");
    idle(3);

    // sample write coincident with a query sees the pre-write history
    smp_vec = {5{8'd200}};
    bus.smp_valid = 1'b1;
    query(255, 106, 5'b11111, "coincident");
    bus.smp_valid = 1'b0;
    query(255, 27, 5'b11111, "post_wr_27");
    query(255, 26, 5'b00000, "post_wr_26");
    query(0, 105, 5'b11111, "post_wr_old");
    query(0, 106, 5'b00000, "post_wr_old_miss");
    idle(3);

    // freeze blocks samples but not queries
    bus.freeze = 1'b1;
    smp_vec = {5{8'd255}};
    bus.smp_valid = 1'b1;
    query(255, 27, 5'b11111, "frz_query");
    idle(9);
    bus.freeze = 1'b0;
    bus.smp_valid = 1'b0;
    query(255, 26, 5'b00000, "frz_unchanged");
    query(0, 105, 5'b11111, "frz_old");
    idle(3);

    // clr: in-flight query uses old state, clr-cycle sample dropped
    bus.clr = 1'b1;
    bus.smp_valid = 1'b1;
    query(255, 27, 5'b11111, "clr_inflight");
    bus.clr = 1'b0;
    bus.smp_valid = 1'b0;
    query(255, 27, 5'b00000, "clr_27");
    query(255, 0, 5'b00000, "clr_0");
    query(0, 105, 5'b00000, "clr_old");
    put(40'h00_00_00_00_FF);
    query(255, 0, 5'b00001, "clr_restart_y0");
    query(255, 127, 5'b11110, "clr_restart_y127");
    query(254, 127, 5'b00000, "clr_restart_unpop");
    idle(3);

    // back-to-back queries against the reference model
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      bus.freeze    = ($urandom_range(0, 7) == 0);
      bus.clr       = (i == 600);
      bus.smp_valid = $urandom_range(0, 1);
      smp_vec       = {8'($urandom), 32'($urandom)};
      x = $urandom_range(0, COLS - 1);
      y = $urandom_range(0, ROWS - 1);
      if ($urandom_range(0, 1) == 1 && hist_q.size() > 0) begin
        x  = COLS - 1 - $urandom_range(0, hist_q.size() - 1);
        ch = $urandom_range(0, 4);
        v8 = hist_q[x - (COLS - hist_q.size())][8*ch +: 8];
        y  = ROWS - 1 - int'(v8 >> 1);
      end
      bus.px_req = 1'b1;
      bus.px_x   = 8'(x);
      bus.px_y   = 7'(y);
      q_exp      = model_code(x, y);
      q_tag      = "rand";
      tick();
    end
    bus.px_req = 1'b0; bus.freeze = 1'b0; bus.clr = 1'b0; bus.smp_valid = 1'b0;
    idle(3);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
